// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: latches per-character settings on go, drives
// tip/lstclk to the clock generator, shifts tx_data out on mosi and
// assembles miso into rx_data using the clock generator's pre-edge strobes.
module spi_xfer_ctrl #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic              wb_clk,
  input  logic              wb_reset,
  input  logic              go,
  input  logic [LEN_W-1:0]  char_len,
  input  logic              lsb,
  input  logic              tx_neg,
  input  logic              rx_neg,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              pos_edge,
  input  logic              neg_edge,
  input  logic              miso,
  output logic              tip,
  output logic              lstclk,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done
);

  // One extra bit so a full DATA_W-bit character is representable.
  localparam int CNT_W = LEN_W + 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   tx_idx_q, tx_idx_d;
  logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic               rx_seen_q, rx_seen_d;
  logic               lsb_q, lsb_d;
  logic               tx_neg_q, tx_neg_d;
  logic               rx_neg_q, rx_neg_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               mosi_q, mosi_d;
  logic               tip_q, tip_d;
  logic               lstclk_q, lstclk_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               tx_stb, rx_stb;
  logic [CNT_W-1:0]   last_cnt, nxt_cnt, msb_cnt;
  logic [IDX_W-1:0]   last_idx, nxt_idx, msb_idx, rx_idx;

  // Strobe selection from the latched mode bits.
  assign tx_stb = tx_neg_q ? neg_edge : pos_edge;
  assign rx_stb = rx_neg_q ? neg_edge : pos_edge;

  // Bit index arithmetic; only the low IDX_W bits address the data words.
  always_comb begin
    last_cnt = len_q - CNT_W'(1);
    nxt_cnt  = tx_idx_q + CNT_W'(1);
    msb_cnt  = len_q - CNT_W'(2) - tx_idx_q;
    last_idx = last_cnt[IDX_W-1:0];
    nxt_idx  = nxt_cnt[IDX_W-1:0];
    msb_idx  = msb_cnt[IDX_W-1:0];
    rx_idx   = rx_cnt_q[IDX_W-1:0];
  end

  // Next-state and next-output logic for the IDLE/LOAD/SHIFT/FIN sequence.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    tx_idx_d  = tx_idx_q;
    rx_cnt_d  = rx_cnt_q;
    rx_seen_d = rx_seen_q;
    lsb_d     = lsb_q;
    tx_neg_d  = tx_neg_q;
    rx_neg_d  = rx_neg_q;
    tx_data_d = tx_data_q;
    rx_data_d = rx_data_q;
    mosi_d    = mosi_q;
    tip_d     = tip_q;
    lstclk_d  = lstclk_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        tip_d    = 1'b0;
        lstclk_d = 1'b0;
        if (go) begin
          lsb_d     = lsb;
          tx_neg_d  = tx_neg;
          rx_neg_d  = rx_neg;
          tx_data_d = tx_data;
          rx_data_d = '0;
          len_d     = (char_len == '0) ? CNT_W'(DATA_W) : {1'b0, char_len};
          state_d   = LOAD;
        end
      end
      LOAD: begin
        mosi_d    = lsb_q ? tx_data_q[0] : tx_data_q[last_idx];
        tx_idx_d  = '0;
        rx_cnt_d  = '0;
        rx_seen_d = 1'b0;
        tip_d     = 1'b1;
        lstclk_d  = (len_q == CNT_W'(1));
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (rx_cnt_q == len_q) begin
          tip_d    = 1'b0;
          lstclk_d = 1'b0;
          done_d   = 1'b1;
          state_d  = FIN;
        end else begin
          // Sample first so a coincident launch sees rx_seen already set.
          if (rx_stb) begin
            if (lsb_q) rx_data_d[rx_idx] = miso;
            else       rx_data_d = {rx_data_q[DATA_W-2:0], miso};
            rx_cnt_d  = rx_cnt_q + CNT_W'(1);
            rx_seen_d = 1'b1;
          end
          // A launch before any sample is the leading edge and is skipped.
          if (tx_stb && rx_seen_d && (nxt_cnt < len_q)) begin
            tx_idx_d  = nxt_cnt;
            mosi_d    = lsb_q ? tx_data_q[nxt_idx] : tx_data_q[msb_idx];
            rx_seen_d = 1'b0;
          end
          lstclk_d = (rx_cnt_d == last_cnt);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transfer without done.
  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      tx_idx_q  <= '0;
      rx_cnt_q  <= '0;
      rx_seen_q <= 1'b0;
      lsb_q     <= 1'b0;
      tx_neg_q  <= 1'b0;
      rx_neg_q  <= 1'b0;
      tx_data_q <= '0;
      rx_data_q <= '0;
      mosi_q    <= 1'b0;
      tip_q     <= 1'b0;
      lstclk_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      tx_idx_q  <= tx_idx_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_seen_q <= rx_seen_d;
      lsb_q     <= lsb_d;
      tx_neg_q  <= tx_neg_d;
      rx_neg_q  <= rx_neg_d;
      tx_data_q <= tx_data_d;
      rx_data_q <= rx_data_d;
      mosi_q    <= mosi_d;
      tip_q     <= tip_d;
      lstclk_q  <= lstclk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tip     = tip_q;
  assign lstclk  = lstclk_q;
  assign mosi    = mosi_q;
  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: expected mosi bits and rx words are
// queued when a transfer is launched and popped as the DUT produces them.
module tb_spi_xfer_ctrl;

  logic        wb_clk = 1'b0;
  logic        wb_reset;
  logic        go;
  logic [4:0]  char_len;
  logic        lsb, tx_neg, rx_neg;
  logic [31:0] tx_data;
  logic        pos_edge, neg_edge;
  logic        miso;
  logic        tip, lstclk, mosi, busy, done;
  logic [31:0] rx_data;

  logic        loop_en;
  logic        miso_fix;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic        exp_q[$];
  logic [31:0] rx_q[$];

  always #5 wb_clk = ~wb_clk;

  assign miso = loop_en ? mosi : miso_fix;

  spi_xfer_ctrl #(.DATA_W(32), .LEN_W(5)) dut (
    .wb_clk(wb_clk), .wb_reset(wb_reset), .go(go), .char_len(char_len),
    .lsb(lsb), .tx_neg(tx_neg), .rx_neg(rx_neg), .tx_data(tx_data),
    .pos_edge(pos_edge), .neg_edge(neg_edge), .miso(miso),
    .tip(tip), .lstclk(lstclk), .mosi(mosi), .rx_data(rx_data),
    .busy(busy), .done(done)
  );

  // Each registered done pulse is seen at exactly one falling edge per cycle high.
  always @(negedge wb_clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer: strobes every 4 cycles, alternating, optional go during
  // SHIFT (midgo) and optional reset after abort_at samples.
  task automatic run_xfer(input logic [4:0] len_cfg, input logic lsb_i,
                          input logic txn, input logic rxn, input logic [31:0] data,
                          input logic loop_i, input logic first_pos,
                          input logic midgo, input int abort_at);
    int          L, k, d0;
    logic [63:0] mask;
    logic        pos_next, is_rx, e;
    L = (len_cfg == 0) ? 32 : int'(len_cfg);
    mask = (64'd1 << L) - 64'd1;
    @(negedge wb_clk);
    char_len = len_cfg; lsb = lsb_i; tx_neg = txn; rx_neg = rxn;
    tx_data = data; loop_en = loop_i; miso_fix = 1'b1; go = 1'b1;
    for (int j = 0; j < L; j++) exp_q.push_back(lsb_i ? data[j] : data[L-1-j]);
    rx_q.push_back(loop_i ? (data & mask[31:0]) : mask[31:0]);
    d0 = done_cnt;
    @(negedge wb_clk);
    go = 1'b0; tx_data = ~data;
    chk("busy_load", busy, 1);
    chk("tip_load", tip, 0);
    @(negedge wb_clk);
    chk("tip_shift", tip, 1);
    k = 0; pos_next = first_pos;
    for (int s = 0; s < 200 && k < L; s++) begin
      repeat (3) @(negedge wb_clk);
      if (abort_at > 0 && k == abort_at) begin
        #2 wb_reset = 1'b1;
        #1;
        chk("rst_tip", tip, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_rx", rx_data, 0);
        exp_q.delete(); rx_q.delete();
        repeat (3) @(negedge wb_clk);
        wb_reset = 1'b0;
        chk("rst_no_done", done_cnt - d0, 0);
        return;
      end
      is_rx = pos_next ? !rxn : rxn;
      if (is_rx) begin
        e = exp_q.pop_front();
        chk("mosi", mosi, e);
        chk("lstclk", lstclk, (k == L-1));
        k++;
        if (midgo && k == 3) begin go = 1'b1; tx_data = 32'h0; end
      end
      if (pos_next) pos_edge = 1'b1; else neg_edge = 1'b1;
      @(negedge wb_clk);
      pos_edge = 1'b0; neg_edge = 1'b0; go = 1'b0;
      pos_next = !pos_next;
    end
    chk("rx_samples", k, L);
    for (int c = 0; c < 10 && done_cnt == d0; c++) @(negedge wb_clk);
    chk("done_seen", done_cnt - d0, 1);
    chk("rx_data", rx_data, rx_q.pop_front());
    repeat (3) @(negedge wb_clk);
    chk("idle_busy", busy, 0);
    chk("idle_tip", tip, 0);
    chk("done_once", done_cnt - d0, 1);
    chk("rx_hold", rx_data, loop_i ? (data & mask[31:0]) : mask[31:0]);
  endtask

  initial begin
    wb_reset = 1'b1; go = 1'b0; char_len = '0; lsb = 1'b0; tx_neg = 1'b0;
    rx_neg = 1'b0; tx_data = '0; pos_edge = 1'b0; neg_edge = 1'b0;
    loop_en = 1'b0; miso_fix = 1'b0;
    repeat (2) @(negedge wb_clk);
    chk("reset_tip", tip, 0);
    chk("reset_lstclk", lstclk, 0);
    chk("reset_mosi", mosi, 0);
    chk("reset_rx", rx_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    wb_reset = 1'b0;

    run_xfer(5'd8, 1'b0, 1'b1, 1'b0, 32'hA5,       1'b1, 1'b1, 1'b0, 0);
    run_xfer(5'd4, 1'b1, 1'b1, 1'b0, 32'h6,        1'b0, 1'b1, 1'b0, 0);
    run_xfer(5'd0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 0);
    run_xfer(5'd8, 1'b0, 1'b0, 1'b1, 32'h3C,       1'b1, 1'b1, 1'b0, 0);
    run_xfer(5'd8, 1'b0, 1'b1, 1'b0, 32'h5A,       1'b1, 1'b1, 1'b1, 0);
    run_xfer(5'd8, 1'b0, 1'b1, 1'b0, 32'hFF,       1'b1, 1'b1, 1'b0, 3);
    run_xfer(5'd8, 1'b1, 1'b1, 1'b0, 32'hC3,       1'b1, 1'b1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transfer sequencer for the SPI master datapath.
- Accepts a start command plus per-character settings.
- Drives tip/lstclk into the SPI clock generator and consumes its pre-edge strobes.
- Serialises tx_data onto mosi, deserialises miso into rx_data, and reports completion.
- Sits between the Wishbone register block and the clock generator / pad logic.

Parameters:
DATA_W, 32, max character width in bits
LEN_W, 5, width of char_len; char_len==0 encodes DATA_W bits

Ports:
wb_clk  in  1  system clock
wb_reset  in  1  reset, asynchronous, active-high
go  in  1  start request; sampled only in IDLE
char_len  in  LEN_W  bits per transfer (0 -> DATA_W); latched at start
lsb  in  1  1 = LSB first, 0 = MSB first; latched at start
tx_neg  in  1  1 = launch mosi on falling-edge strobe, 0 = rising; latched
rx_neg  in  1  1 = sample miso on falling-edge strobe, 0 = rising; latched
tx_data  in  DATA_W  transmit word; latched at start
pos_edge  in  1  one-cycle strobe from clock generator preceding sclk rising edge
neg_edge  in  1  one-cycle strobe preceding sclk falling edge
miso  in  1  serial input, already synchronised
tip  out  1  transfer in progress; enables clock generator
lstclk  out  1  last-bit indicator to clock generator
mosi  out  1  serial output
rx_data  out  DATA_W  received word
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: tip=0, lstclk=0, mosi=0, rx_data=0, busy=0, done=0, state=IDLE, counters=0. Asynchronous; reset mid-transfer aborts immediately with no done pulse.
- Edge selection: tx_stb = tx_neg ? neg_edge : pos_edge; rx_stb = rx_neg ? neg_edge : pos_edge. Uses latched copies of the mode bits.
- FSM states: IDLE, LOAD, SHIFT, FIN.
- IDLE: on go=1, latch settings and tx_data, clear rx_data, set len = (char_len==0 ? DATA_W : char_len) -> LOAD. go while busy is ignored (no queueing).
- LOAD (1 cycle):
  - mosi = first bit: tx_data[0] if lsb, else tx_data[len-1].
  - tx_idx=0, rx_cnt=0, rx_seen=0 -> SHIFT.
- SHIFT: tip=1.
  - rx_stb: capture miso. MSB-first: rx_data = {rx_data[DATA_W-2:0], miso}. LSB-first: rx_data[rx_cnt] = miso. Then rx_cnt++ and rx_seen=1.
  - tx_stb with rx_seen=1 and tx_idx+1 < len: tx_idx++, mosi = next bit, rx_seen=0.
  - tx_stb with rx_seen=0 is ignored (a leading launch edge).
  - When tx_stb and rx_stb coincide, the rx update and its rx_seen=1 are applied first, within the same cycle.
  - lstclk=1 while rx_cnt == len-1.
  - When rx_cnt reaches len (the cycle after the last sample) -> FIN.
- FIN (1 cycle): tip=0, lstclk=0, done=1 -> IDLE.
  - rx_data holds its result until the next go.
  - mosi holds its last bit.
- Result alignment: received bits occupy rx_data[len-1:0]; upper bits are 0.
- Latency: go -> tip rises 2 cycles later (IDLE->LOAD->SHIFT).
- Arithmetic: tx_idx and rx_cnt are LEN_W+1 bits wide, so DATA_W is representable with no wrap.
- Strobes are ignored outside SHIFT.

Test Plan:
- Mode 0 (tx_neg=1, rx_neg=0, lsb=0), char_len=8, tx_data=0xA5, miso looped to mosi, strobes alternating every 4 cycles starting with pos_edge:
  - mosi sequence 1,0,1,0,0,1,0,1.
  - rx_data=0x000000A5.
  - done exactly one pulse; lstclk high only during bit 7.
- LSB-first, char_len=4, tx_data=0x6, miso tied 1:
  - mosi 0,1,1,0.
  - rx_data=0x0000000F.
- char_len=0, tx_data=0xDEADBEEF, loopback: 32 rx samples; rx_data=0xDEADBEEF; counters do not wrap.
- tx_neg=0, rx_neg=1, first strobe is pos_edge:
  - first tx_stb ignored; mosi changes only after each neg-edge sample.
  - 8-bit loopback of 0x3C returns 0x3C.
- go pulsed during SHIFT: ignored; transfer completes with the original data; a single done pulse.
- wb_reset asserted at bit 3:
  - tip, busy, mosi, rx_data all 0 immediately; no done pulse.
  - A subsequent go runs a clean transfer.
